// File: rtl/pci_pkg.sv
// Shared PCI initiator definitions: command codes, completion status and FSM states.
package pci_pkg;

    localparam logic [3:0] IO_RD  = 4'h2;
    localparam logic [3:0] IO_WR  = 4'h3;
    localparam logic [3:0] MEM_RD = 4'h6;
    localparam logic [3:0] MEM_WR = 4'h7;
    localparam logic [3:0] CFG_RD = 4'hA;
    localparam logic [3:0] CFG_WR = 4'hB;

    typedef enum logic [2:0] {
        RspOk          = 3'd0,
        RspMasterAbort = 3'd1,
        RspTargetAbort = 3'd2,
        RspRetry       = 3'd3,
        RspParity      = 3'd4
    } pci_status_e;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StAddr,
        StData,
        StTurn,
        StResp
    } pci_state_e;

    function automatic logic is_cfg(input logic [3:0] code);
        return (code == CFG_RD) || (code == CFG_WR);
    endfunction

    // Bit 0 of every PCI command marks the write direction.
    function automatic logic is_write(input logic [3:0] code);
        return code[0];
    endfunction

endpackage

// File: rtl/pci_parity_gen.sv
// Registered even-parity generator over AD[31:0] and C/BE#[3:0].
module pci_parity_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ad_i,
    input  logic [3:0]  cbe_i,
    output logic        par_o
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_o <= 1'b0;
        end else begin
            par_o <= ^{ad_i, cbe_i};
        end
    end

endmodule

// File: rtl/pci_host_initiator.sv
// Single-data-phase PCI bus master: arbitration, address/data phases, termination handling
// and completion reporting on a valid/ready command port.
module pci_host_initiator
    import pci_pkg::*;
#(
    parameter int unsigned DEVSEL_TIMEOUT = 5,
    parameter int unsigned RETRY_MAX      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_code,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  rsp_status,
    input  logic [31:0] ad_in,
    output logic [31:0] ad_out,
    output logic        ad_en,
    output logic [3:0]  cbe_out,
    output logic        cbe_en,
    input  logic        par_in,
    output logic        par_out,
    output logic        par_en,
    input  logic        frame_in,
    output logic        frame_out,
    output logic        frame_en,
    input  logic        irdy_in,
    output logic        irdy_out,
    output logic        irdy_en,
    input  logic        trdy_in,
    input  logic        stop_in,
    input  logic        devsel_in,
    input  logic        gnt,
    output logic        req,
    output logic        idsel
);

    localparam int unsigned RetryW  = $clog2(RETRY_MAX + 1);
    localparam int unsigned DevselW = $clog2(DEVSEL_TIMEOUT + 1);

    pci_state_e          state_q, state_d;
    pci_status_e         status_q, status_d;
    logic [3:0]          code_q, be_q;
    logic [31:0]         addr_q, wdata_q, rdata_q, rdata_d;
    logic [RetryW-1:0]   retry_cnt_q, retry_cnt_d;
    logic [DevselW-1:0]  wait_cnt_q, wait_cnt_d;
    logic                devsel_seen_q, devsel_seen_d;
    logic                retry_q, retry_d;
    logic                chk_q, chk_d;
    logic                ready_q, par_en_q;
    logic                rd_par;
    logic                accept, xfer, retry_hit, tabort, mabort;

    assign accept    = cmd_valid && cmd_ready;
    assign xfer      = !trdy_in && !devsel_in;
    assign retry_hit = !stop_in && trdy_in && !devsel_in;
    assign tabort    = !stop_in && devsel_in && devsel_seen_q;
    assign mabort    = devsel_in && !devsel_seen_q && (wait_cnt_q == DevselW'(DEVSEL_TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StArb;
            StArb:  if (!gnt && frame_in && irdy_in) state_d = StAddr;
            StAddr: state_d = StData;
            StData: if (xfer || retry_hit || tabort || mabort) state_d = StTurn;
            StTurn: state_d = (retry_q && (retry_cnt_q < RetryW'(RETRY_MAX))) ? StArb : StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        req       = 1'b1;
        idsel     = 1'b0;
        ad_out    = '0;
        ad_en     = 1'b0;
        cbe_out   = 4'hF;
        cbe_en    = 1'b0;
        frame_out = 1'b1;
        frame_en  = 1'b0;
        irdy_out  = 1'b1;
        irdy_en   = 1'b0;
        unique case (state_q)
            StIdle: cmd_ready = ready_q;
            StArb:  req = 1'b0;
            StAddr: begin
                frame_out = 1'b0;
                frame_en  = 1'b1;
                ad_out    = addr_q;
                ad_en     = 1'b1;
                cbe_out   = code_q;
                cbe_en    = 1'b1;
                idsel     = is_cfg(code_q);
            end
            StData: begin
                frame_en = 1'b1;
                irdy_out = 1'b0;
                irdy_en  = 1'b1;
                cbe_out  = be_q;
                cbe_en   = 1'b1;
                if (is_write(code_q)) begin
                    ad_out = wdata_q;
                    ad_en  = 1'b1;
                end
            end
            StTurn: begin
                frame_en = 1'b1;
                irdy_en  = 1'b1;
            end
            StResp: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rdata_d       = rdata_q;
        status_d      = status_q;
        retry_cnt_d   = retry_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        devsel_seen_d = devsel_seen_q;
        retry_d       = retry_q;
        chk_d         = 1'b0;
        unique case (state_q)
            StIdle: if (accept) begin
                rdata_d     = '0;
                status_d    = RspOk;
                retry_cnt_d = '0;
            end
            StAddr: begin
                wait_cnt_d    = '0;
                devsel_seen_d = 1'b0;
                retry_d       = 1'b0;
            end
            StData: begin
                if (!devsel_in) begin
                    devsel_seen_d = 1'b1;
                end else if (!devsel_seen_q && !mabort) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (xfer) begin
                    status_d = RspOk;
                    if (!is_write(code_q)) begin
                        rdata_d = ad_in;
                        chk_d   = 1'b1;
                    end
                end else if (retry_hit) begin
                    status_d = RspRetry;
                    retry_d  = 1'b1;
                    if (retry_cnt_q != RetryW'(RETRY_MAX)) retry_cnt_d = retry_cnt_q + 1'b1;
                end else if (tabort) begin
                    status_d = RspTargetAbort;
                end else if (mabort) begin
                    status_d = RspMasterAbort;
                    rdata_d  = '1;
                end
            end
            // Target drives PAR one clock after the read transfer.
            StTurn: if (chk_q && (par_in != rd_par)) status_d = RspParity;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q      <= RspOk;
            rdata_q       <= '0;
            retry_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            devsel_seen_q <= 1'b0;
            retry_q       <= 1'b0;
            chk_q         <= 1'b0;
            ready_q       <= 1'b0;
            par_en_q      <= 1'b0;
            code_q        <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
        end else begin
            status_q      <= status_d;
            rdata_q       <= rdata_d;
            retry_cnt_q   <= retry_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            devsel_seen_q <= devsel_seen_d;
            retry_q       <= retry_d;
            chk_q         <= chk_d;
            ready_q       <= 1'b1;
            par_en_q      <= ad_en;
            if (accept) begin
                code_q  <= cmd_code;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                be_q    <= cmd_be;
            end
        end
    end

    assign par_en     = par_en_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

    pci_parity_gen u_par_out (
        .clk   (clk),
        .rst   (rst),
        .ad_i  (ad_out),
        .cbe_i (cbe_out),
        .par_o (par_out)
    );

    pci_parity_gen u_par_chk (
        .clk   (clk),
        .rst   (rst),
        .ad_i  (ad_in),
        .cbe_i (cbe_out),
        .par_o (rd_par)
    );

endmodule

// File: tb/tb_pci_host_initiator.sv
// Scoreboard bench for pci_host_initiator with a reactive behavioural PCI target.
`timescale 1ns/1ps
module tb_pci_host_initiator;
    import pci_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [3:0]  cmd_code = '0, cmd_be = '0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  rsp_status;
    logic [31:0] ad_in, ad_out;
    logic        ad_en, cbe_en, par_in, par_out, par_en;
    logic [3:0]  cbe_out;
    logic        frame_in, frame_out, frame_en, irdy_in, irdy_out, irdy_en;
    logic        trdy_in = 1'b1, stop_in = 1'b1, devsel_in = 1'b1, gnt = 1'b0;
    logic        req, idsel;

    logic [31:0] tgt_ad = '0;
    logic        tgt_par = 1'b0;

    always #5 clk = ~clk;

    assign ad_in    = ad_en ? ad_out : tgt_ad;
    assign par_in   = par_en ? par_out : tgt_par;
    assign frame_in = frame_en ? frame_out : 1'b1;
    assign irdy_in  = irdy_en ? irdy_out : 1'b1;

    pci_host_initiator dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .ad_in(ad_in), .ad_out(ad_out), .ad_en(ad_en),
        .cbe_out(cbe_out), .cbe_en(cbe_en),
        .par_in(par_in), .par_out(par_out), .par_en(par_en),
        .frame_in(frame_in), .frame_out(frame_out), .frame_en(frame_en),
        .irdy_in(irdy_in), .irdy_out(irdy_out), .irdy_en(irdy_en),
        .trdy_in(trdy_in), .stop_in(stop_in), .devsel_in(devsel_in),
        .gnt(gnt), .req(req), .idsel(idsel)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  status;
    } exp_t;
    exp_t sb_q[$];

    // Target behaviour knobs: 0 = respond (after n_retry retries), 1 = never claim, 2 = abort.
    int          mode = 0;
    int          dv_lat = 0, tr_lat = 0, n_retry = 0;
    logic [31:0] tgt_rdata = '0;
    logic        tgt_bad_par = 1'b0;

    int          cyc = 0, addr_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
    int          addr_cnt = 0, idsel_addr = 0, idsel_bad = 0, frame_bad = 0, k = 0;
    logic [31:0] ad_seen = '0;
    logic [3:0]  be_seen = '0;
    logic        par_seen = 1'b0, par_en_seen = 1'b0, wr_prev = 1'b0, xfer_prev = 1'b0;
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    // Reactive target: drives DEVSEL#/TRDY#/STOP#/AD/PAR half a clock ahead of sampling.
    always @(negedge clk) begin
        if (!rst) begin
            k = 0;
            devsel_in = 1'b1; trdy_in = 1'b1; stop_in = 1'b1;
            wr_prev = 1'b0; xfer_prev = 1'b0;
        end else begin
            if (frame_en && !frame_out) begin
                addr_cnt++;
                addr_cyc = cyc;
            end
            if (idsel) begin
                if (frame_en && !frame_out) idsel_addr++;
                else idsel_bad++;
            end
            if (wr_prev) begin
                par_seen    = par_out;
                par_en_seen = par_en;
            end
            tgt_par = xfer_prev ? (^{tgt_rdata, be_seen}) ^ tgt_bad_par : 1'b0;
            wr_prev = 1'b0;
            xfer_prev = 1'b0;
            if (irdy_en && !irdy_out) begin
                if (!frame_out) frame_bad++;
                devsel_in = 1'b1; trdy_in = 1'b1; stop_in = 1'b1;
                if (mode == 0 && k >= dv_lat) begin
                    devsel_in = 1'b0;
                    if (addr_cnt <= n_retry) begin
                        stop_in = 1'b0;
                    end else if (k >= tr_lat) begin
                        trdy_in   = 1'b0;
                        tgt_ad    = tgt_rdata;
                        be_seen   = cbe_out;
                        xfer_prev = 1'b1;
                    end
                end else if (mode == 2) begin
                    if (k == 0) devsel_in = 1'b0;
                    else stop_in = 1'b0;
                end
                if (ad_en) begin
                    ad_seen = ad_out;
                    wr_prev = 1'b1;
                end
                k++;
            end else begin
                k = 0;
                devsel_in = 1'b1; trdy_in = 1'b1; stop_in = 1'b1;
            end
        end
    end

    // Monitor: every completion is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            check("rsp_en_off", {27'd0, ad_en, cbe_en, par_en, frame_en, irdy_en}, 32'd0);
            check("rsp_expected", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_status", {29'd0, rsp_status}, {29'd0, e.status});
            end
        end
    end

    task automatic issue(input logic [3:0] code, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] exp_rd, input logic [2:0] exp_st,
                         input bit push);
        int t;
        exp_t x;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        x.rdata  = exp_rd;
        x.status = exp_st;
        if (push) sb_q.push_back(x);
        addr_cnt = 0; idsel_addr = 0; idsel_bad = 0; frame_bad = 0;
        cmd_valid = 1'b1; cmd_code = code; cmd_addr = addr; cmd_wdata = wd; cmd_be = be;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_code = 4'hF; cmd_addr = 32'hDEAD_BEEF; cmd_wdata = 32'h0BAD_0BAD; cmd_be = 4'h5;
    endtask

    task automatic wait_rsp(input int n0, input int exp_lat);
        int t;
        t = 0;
        while (rsp_cnt == n0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("rsp_seen", rsp_cnt, n0 + 1);
        if (exp_lat >= 0) check("rsp_latency", rsp_cyc - addr_cyc, exp_lat);
    endtask

    task automatic set_tgt(input int m, input int dv, input int tr, input int nr,
                           input logic [31:0] rd, input logic bad);
        mode = m; dv_lat = dv; tr_lat = tr; n_retry = nr; tgt_rdata = rd; tgt_bad_par = bad;
    endtask

    initial begin
        int n0, t;
        #2;
        check("rst_en", {27'd0, ad_en, cbe_en, par_en, frame_en, irdy_en}, 32'd0);
        check("rst_ctl", {26'd0, req, frame_out, irdy_out, idsel, cmd_ready, rsp_valid},
              32'h38);
        check("rst_ad", ad_out, 32'd0);
        check("rst_cbe_par", {27'd0, cbe_out, par_out}, 32'h1E);
        check("rst_rsp", rsp_rdata | {29'd0, rsp_status}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Config read: DEVSEL# on data clock 1, TRDY# on clock 2.
        set_tgt(0, 1, 2, 0, 32'h1234_1111, 1'b0);
        n0 = rsp_cnt;
        issue(CFG_RD, 32'h0000_0000, 32'h0, 4'h0, 32'h1234_1111, RspOk, 1'b1);
        wait_rsp(n0, 5);
        check("cfg_idsel_addr", idsel_addr, 1);
        check("cfg_idsel_other", idsel_bad, 0);

        // Zero-wait memory writes; data-phase parity lands on the following clock.
        set_tgt(0, 0, 0, 0, 32'h0, 1'b0);
        n0 = rsp_cnt;
        issue(MEM_WR, 32'hFEBF_0004, 32'hA5A5_5A5A, 4'h0, 32'h0, RspOk, 1'b1);
        wait_rsp(n0, 3);
        check("wr_ad", ad_seen, 32'hA5A5_5A5A);
        check("wr_par", {30'd0, par_en_seen, par_seen}, 32'h2);
        check("mem_idsel", idsel_addr + idsel_bad, 0);
        n0 = rsp_cnt;
        issue(MEM_WR, 32'h0000_1000, 32'h0000_0001, 4'h0, 32'h0, RspOk, 1'b1);
        wait_rsp(n0, 3);
        check("wr_par_odd", {30'd0, par_en_seen, par_seen}, 32'h3);

        // I/O read with one TRDY# wait state and correct parity.
        set_tgt(0, 0, 1, 0, 32'h8000_0001, 1'b0);
        n0 = rsp_cnt;
        issue(IO_RD, 32'h0000_0300, 32'h0, 4'hE, 32'h8000_0001, RspOk, 1'b1);
        wait_rsp(n0, 4);

        // Master abort: nobody claims the cycle.
        set_tgt(1, 0, 0, 0, 32'h0, 1'b0);
        n0 = rsp_cnt;
        issue(MEM_RD, 32'h1000_0000, 32'h0, 4'h0, 32'hFFFF_FFFF, RspMasterAbort, 1'b1);
        wait_rsp(n0, 8);
        check("ma_frame_high", frame_bad, 0);

        // Three retries then success; endless retry gives up after sixteen.
        set_tgt(0, 0, 0, 3, 32'h0, 1'b0);
        n0 = rsp_cnt;
        issue(MEM_WR, 32'h2000_0000, 32'h1111_2222, 4'h0, 32'h0, RspOk, 1'b1);
        wait_rsp(n0, 3);
        check("retry3_addr_phases", addr_cnt, 4);
        set_tgt(0, 0, 0, 100, 32'h0, 1'b0);
        n0 = rsp_cnt;
        issue(MEM_RD, 32'h2000_0004, 32'h0, 4'h0, 32'h0, RspRetry, 1'b1);
        wait_rsp(n0, 3);
        check("retry16_addr_phases", addr_cnt, 16);

        // Target abort, then a read returned with bad parity.
        set_tgt(2, 0, 0, 0, 32'h0, 1'b0);
        n0 = rsp_cnt;
        issue(MEM_RD, 32'h3000_0000, 32'h0, 4'h0, 32'h0, RspTargetAbort, 1'b1);
        wait_rsp(n0, 4);
        set_tgt(0, 0, 0, 0, 32'hCAFE_F00D, 1'b1);
        n0 = rsp_cnt;
        issue(MEM_RD, 32'h3000_0010, 32'h0, 4'h0, 32'hCAFE_F00D, RspParity, 1'b1);
        wait_rsp(n0, 3);

        // GNT# withheld: the master must keep requesting and not start a cycle.
        set_tgt(0, 0, 0, 0, 32'h0, 1'b0);
        gnt = 1'b1;
        n0 = rsp_cnt;
        issue(MEM_WR, 32'h4000_0000, 32'h5555_AAAA, 4'h3, 32'h0, RspOk, 1'b1);
        repeat (5) @(negedge clk);
        check("arb_req_low", {31'd0, req}, 32'd0);
        check("arb_no_addr", addr_cnt, 0);
        gnt = 1'b0;
        wait_rsp(n0, 3);

        // Reset during the data phase aborts silently; the next request is clean.
        set_tgt(1, 0, 0, 0, 32'h0, 1'b0);
        n0 = rsp_cnt;
        issue(MEM_RD, 32'h5000_0000, 32'h0, 4'h0, 32'h0, RspOk, 1'b0);
        t = 0;
        while (!(irdy_en && !irdy_out) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("reached_data", {31'd0, irdy_en}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_en", {27'd0, ad_en, cbe_en, par_en, frame_en, irdy_en}, 32'd0);
        check("midrst_ctl", {29'd0, req, rsp_valid, cmd_ready}, 32'h4);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_rsp", rsp_cnt, n0);
        set_tgt(0, 0, 0, 0, 32'h7777_0001, 1'b0);
        n0 = rsp_cnt;
        issue(MEM_RD, 32'h5000_0004, 32'h0, 4'h0, 32'h7777_0001, RspOk, 1'b1);
        wait_rsp(n0, 3);

        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
